// File: rtl/lathe_pkg.sv
// Shared types and constants for the lathe turning-cycle sequencer.
package lathe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MANUAL = 3'd1,
    ST_SPINUP = 3'd2,
    ST_FEED   = 3'd3,
    ST_COAST  = 3'd4,
    ST_FAULT  = 3'd5
  } lathe_state_e;

  localparam logic [1:0] FLT_NONE  = 2'd0;
  localparam logic [1:0] FLT_ESTOP = 2'd1;
  localparam logic [1:0] FLT_GUARD = 2'd2;
  localparam logic [1:0] FLT_TMO   = 2'd3;

  // Width that holds the largest of the three phase durations.
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lathe_cyc_timer.sv
// Shared phase timer: clears on state entry, counts while run is high.
module lathe_cyc_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clr,
  input  logic             run,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (ena)
      cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/lathe_cycle_seq.sv
// Lathe auto/manual cycle sequencer with latched safety faults.
// Coolant control is built only when LATHE_COOLANT_EN is defined.
module lathe_cycle_seq
  import lathe_pkg::*;
#(
  parameter int SPINUP_CYC   = 150_000_000,
  parameter int FEED_TMO_CYC = 1_500_000_000,
  parameter int COAST_CYC    = 100_000_000,
  parameter int CNT_W        =
    cnt_width(SPINUP_CYC, FEED_TMO_CYC, COAST_CYC)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       auto_mode,
  input  logic       man_mode,
  input  logic       estop_n,
  input  logic       guard_closed,
  input  logic       feed_limit,
  input  logic       fault_clr,
  output logic       spindle_en,
  output logic       feed_en,
  output logic       coolant_en,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] SPIN_LAST =
    CNT_W'(SPINUP_CYC - 1);
  localparam logic [CNT_W-1:0] FEED_LAST =
    CNT_W'(FEED_TMO_CYC - 1);
  localparam logic [CNT_W-1:0] COAST_LAST =
    CNT_W'(COAST_CYC - 1);

  lathe_state_e     state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic             start_q;
  logic [CNT_W-1:0] tmr;
  logic             tmr_clr, tmr_run;

  logic start_rise, ok_auto, ok_man, guarded;

  assign start_rise = start & ~start_q;
  assign ok_auto    = auto_mode & ~man_mode;
  assign ok_man     = man_mode & ~auto_mode;
  assign guarded    = (state_q == ST_MANUAL) |
                      (state_q == ST_SPINUP) |
                      (state_q == ST_FEED);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (state_q != ST_FAULT && !estop_n) begin
      state_d = ST_FAULT;
      code_d  = FLT_ESTOP;
    end else if (guarded && !guard_closed) begin
      state_d = ST_FAULT;
      code_d  = FLT_GUARD;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ok_auto && start_rise &&
              guard_closed && !stop)
            state_d = ST_SPINUP;
          else if (ok_man && start &&
                   guard_closed && !stop)
            state_d = ST_MANUAL;
        end
        ST_MANUAL: begin
          if (!start || !ok_man || stop)
            state_d = ST_IDLE;
        end
        ST_SPINUP: begin
          if (stop || !ok_auto)
            state_d = ST_COAST;
          else if (tmr == SPIN_LAST)
            state_d = ST_FEED;
        end
        ST_FEED: begin
          // limit switch beats a simultaneous timeout
          if (stop || feed_limit || !ok_auto) begin
            state_d = ST_COAST;
          end else if (tmr == FEED_LAST) begin
            state_d = ST_FAULT;
            code_d  = FLT_TMO;
          end
        end
        ST_COAST: begin
          if (tmr == COAST_LAST)
            state_d = ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_clr && estop_n && guard_closed) begin
            state_d = ST_IDLE;
            code_d  = FLT_NONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          code_d  = FLT_NONE;
        end
      endcase
    end
  end

  assign tmr_clr = (state_d != state_q);
  assign tmr_run = (state_q == ST_SPINUP) |
                   (state_q == ST_FEED) |
                   (state_q == ST_COAST);

  lathe_cyc_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .clr   (tmr_clr),
    .run   (tmr_run),
    .count (tmr)
  );

  // start_q resets high so a held start cannot launch a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= FLT_NONE;
      start_q <= 1'b1;
    end else if (ena) begin
      state_q <= state_d;
      code_q  <= code_d;
      start_q <= start;
    end
  end

  always_comb begin
    spindle_en = guarded;
    feed_en    = (state_q == ST_FEED);
    busy       = (state_q != ST_IDLE) &&
                 (state_q != ST_FAULT);
    fault      = (state_q == ST_FAULT);
    fault_code = code_q;
    state_o    = state_q;
  end

`ifdef LATHE_COOLANT_EN
  localparam logic [CNT_W-1:0] COOL_LIM =
    CNT_W'(COAST_CYC / 4);
  assign coolant_en = (state_q == ST_FEED) ||
                      ((state_q == ST_COAST) &&
                       (tmr < COOL_LIM));
`else
  assign coolant_en = 1'b0;
`endif

endmodule

// File: tb/tb_lathe_cycle_seq.sv
// Bench for lathe_cycle_seq: directed scenarios then random
// stimulus, all checked against a phase-level reference model.
module tb_lathe_cycle_seq;

  localparam int SPIN  = 4;
  localparam int TMO   = 20;
  localparam int COAST = 3;

  localparam int P_IDLE   = 0;
  localparam int P_MANUAL = 1;
  localparam int P_SPINUP = 2;
  localparam int P_FEED   = 3;
  localparam int P_COAST  = 4;
  localparam int P_FAULT  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic auto_mode = 1'b0;
  logic man_mode = 1'b0;
  logic estop_n = 1'b1;
  logic guard_closed = 1'b1;
  logic feed_limit = 1'b0;
  logic fault_clr = 1'b0;
  logic spindle_en, feed_en, coolant_en;
  logic busy, fault;
  logic [1:0] fault_code;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase, cycles spent in phase, fault cause
  int m_ph, m_age, m_code;
  bit m_prev_start;

  lathe_cycle_seq #(
    .SPINUP_CYC   (SPIN),
    .FEED_TMO_CYC (TMO),
    .COAST_CYC    (COAST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .start        (start),
    .stop         (stop),
    .auto_mode    (auto_mode),
    .man_mode     (man_mode),
    .estop_n      (estop_n),
    .guard_closed (guard_closed),
    .feed_limit   (feed_limit),
    .fault_clr    (fault_clr),
    .spindle_en   (spindle_en),
    .feed_en      (feed_en),
    .coolant_en   (coolant_en),
    .busy         (busy),
    .fault        (fault),
    .fault_code   (fault_code),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = P_IDLE;
    m_age = 0;
    m_code = 0;
    m_prev_start = 1'b1;
  endtask

  task automatic go(int ph, int code);
    if (ph != m_ph) begin
      m_ph = ph;
      m_age = 0;
      m_code = code;
    end
  endtask

  task automatic model_step();
    bit auto_only, man_only, rise;
    int ph0, age0;
    if (rst) begin
      m_reset();
      return;
    end
    if (!ena) return;
    auto_only = auto_mode && !man_mode;
    man_only  = man_mode && !auto_mode;
    rise = start && !m_prev_start;
    ph0 = m_ph;
    age0 = m_age + 1;
    if (m_ph != P_FAULT && !estop_n)
      go(P_FAULT, 1);
    else if ((m_ph == P_MANUAL || m_ph == P_SPINUP ||
              m_ph == P_FEED) && !guard_closed)
      go(P_FAULT, 2);
    else if (m_ph == P_IDLE) begin
      if (auto_only && rise && guard_closed && !stop)
        go(P_SPINUP, 0);
      else if (man_only && start && guard_closed && !stop)
        go(P_MANUAL, 0);
    end else if (m_ph == P_MANUAL) begin
      if (!start || !man_only || stop) go(P_IDLE, 0);
    end else if (m_ph == P_SPINUP) begin
      if (stop || !auto_only) go(P_COAST, 0);
      else if (age0 >= SPIN) go(P_FEED, 0);
    end else if (m_ph == P_FEED) begin
      if (stop || feed_limit || !auto_only) go(P_COAST, 0);
      else if (age0 >= TMO) go(P_FAULT, 3);
    end else if (m_ph == P_COAST) begin
      if (age0 >= COAST) go(P_IDLE, 0);
    end else begin
      if (fault_clr && estop_n && guard_closed)
        go(P_IDLE, 0);
    end
    if (m_ph == ph0) m_age = age0;
    m_prev_start = start;
  endtask

  function automatic logic [9:0] m_outs();
    logic sp, fd, cl, bz, ft;
    sp = (m_ph == P_MANUAL || m_ph == P_SPINUP ||
          m_ph == P_FEED);
    fd = (m_ph == P_FEED);
`ifdef LATHE_COOLANT_EN
    cl = fd || (m_ph == P_COAST && m_age < COAST / 4);
`else
    cl = 1'b0;
`endif
    bz = (m_ph != P_IDLE && m_ph != P_FAULT);
    ft = (m_ph == P_FAULT);
    return {m_ph[2:0], m_code[1:0], sp, fd, cl, bz, ft};
  endfunction

  function automatic logic [9:0] dut_outs();
    return {state_o, fault_code, spindle_en, feed_en,
            coolant_en, busy, fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("outs", 32'(dut_outs()), 32'(m_outs()));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m_reset();
    #1;
    chk("rst_outs", 32'(dut_outs()), 32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(2);

    // auto cycle
    auto_mode = 1'b1;
    start = 1'b1;
    tick();
    chk("spin_rise", 32'(spindle_en), 32'd1);
    start = 1'b0;
    ticks(3);
    chk("feed_early", 32'(feed_en), 32'd0);
    tick();
    chk("feed_rise", 32'(feed_en), 32'd1);
    ticks(2);
    feed_limit = 1'b1;
    tick();
    feed_limit = 1'b0;
    chk("coast_drv", 32'({spindle_en, feed_en, busy}),
        32'b001);
    ticks(2);
    chk("coast_busy", 32'(busy), 32'd1);
    tick();
    chk("coast_end", 32'(state_o), 32'(P_IDLE));

    // feed watchdog
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);
    ticks(19);
    chk("wd_pre", 32'(state_o), 32'(P_FEED));
    tick();
    chk("wd_fault", 32'({fault, fault_code, spindle_en,
        feed_en}), 32'b11100);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("wd_clr", 32'(state_o), 32'(P_IDLE));

    // e-stop in feed, later guard cause must not overwrite
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4 + 4);
    estop_n = 1'b0;
    tick();
    chk("es_code", 32'(fault_code), 32'd1);
    guard_closed = 1'b0;
    ticks(2);
    chk("es_keep", 32'(fault_code), 32'd1);
    fault_clr = 1'b1;
    tick();
    chk("es_hold", 32'(state_o), 32'(P_FAULT));
    fault_clr = 1'b0;
    estop_n = 1'b1;
    guard_closed = 1'b1;
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("es_clr", 32'({state_o, fault_code}), 32'd0);

    // manual jog
    auto_mode = 1'b0;
    man_mode = 1'b1;
    start = 1'b1;
    tick();
    chk("man_spin", 32'({spindle_en, feed_en}), 32'b10);
    ticks(5);
    start = 1'b0;
    tick();
    chk("man_off", 32'(state_o), 32'(P_IDLE));
    auto_mode = 1'b1;
    start = 1'b1;
    ticks(3);
    chk("both_modes", 32'(state_o), 32'(P_IDLE));
    start = 1'b0;
    man_mode = 1'b0;
    tick();

    // start held through reset
    rst = 1'b1;
    start = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(3);
    chk("held_start", 32'(state_o), 32'(P_IDLE));
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("fresh_start", 32'(state_o), 32'(P_SPINUP));
    start = 1'b0;
    tick();

    // enable freeze mid-spinup
    ena = 1'b0;
    ticks(10);
    chk("frz_state", 32'({state_o, spindle_en}),
        32'({3'(P_SPINUP), 1'b1}));
    ena = 1'b1;
    ticks(2);
    chk("frz_nofeed", 32'(feed_en), 32'd0);
    tick();
    chk("frz_feed", 32'(feed_en), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ticks(3);

    // asynchronous reset mid-feed
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(5);
    rst = 1'b1;
    #1;
    m_reset();
    chk("async_rst", 32'(dut_outs()), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // randomized operation
    for (int c = 0; c < 4000; c++) begin
      ena          = ($urandom_range(0, 9) != 0);
      start        = ($urandom_range(0, 3) == 0) ? ~start
                                                 : start;
      stop         = ($urandom_range(0, 29) == 0);
      estop_n      = ($urandom_range(0, 79) != 0);
      guard_closed = ($urandom_range(0, 59) != 0);
      feed_limit   = ($urandom_range(0, 24) == 0);
      fault_clr    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0)
        auto_mode = ~auto_mode;
      if ($urandom_range(0, 49) == 0)
        man_mode = ~man_mode;
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
